// File: rtl/lane_bank_collector_pkg.sv
// Shared types and defaults for the lane operand collector.
package lane_bank_collector_pkg;
  localparam int DATA_W_DEF    = 32;
  localparam int NUM_BANKS_DEF = 2;
  localparam int RD_PORTS_DEF  = 1;

  typedef logic [DATA_W_DEF-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } collector_state_t;
endpackage

// File: rtl/lane_bank_collector_if.sv
// Command, write-back and result bundle between the lane pipeline and the collector.
interface lane_bank_collector_if #(
  parameter int NUM_SRC = 3,
  parameter int IDX_W   = 6,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
);
  logic                      I_Req;
  logic                      O_Ready;
  logic [NUM_SRC-1:0]        I_Src_V;
  logic [NUM_SRC*IDX_W-1:0]  I_Src_Idx;
  logic                      I_WB_We;
  logic [IDX_W-1:0]          I_WB_Idx;
  logic [DATA_W-1:0]         I_WB_Data;
  logic                      I_Stall;
  logic                      O_Valid;
  logic [NUM_SRC-1:0]        O_Src_V;
  logic [NUM_SRC*DATA_W-1:0] O_Src_Data;
  logic [CNT_W-1:0]          O_Conflict_Cnt;

  modport master (
    output I_Req, I_Src_V, I_Src_Idx, I_WB_We, I_WB_Idx, I_WB_Data, I_Stall,
    input  O_Ready, O_Valid, O_Src_V, O_Src_Data, O_Conflict_Cnt
  );

  modport slave (
    input  I_Req, I_Src_V, I_Src_Idx, I_WB_We, I_WB_Idx, I_WB_Data, I_Stall,
    output O_Ready, O_Valid, O_Src_V, O_Src_Data, O_Conflict_Cnt
  );
endinterface

// File: rtl/lane_bank_collector_bank_grant.sv
// Per-bank read-port arbiter: hands each port the lowest pending source on this bank.
module lane_bank_collector_bank_grant #(
  parameter int NUM_SRC  = 3,
  parameter int RD_PORTS = 1
) (
  input  logic [NUM_SRC-1:0]                pend_i,
  input  logic [NUM_SRC-1:0]                match_i,
  output logic [RD_PORTS-1:0][NUM_SRC-1:0]  gnt_o
);
  logic [NUM_SRC-1:0] rem;

  always_comb begin
    rem   = pend_i & match_i;
    gnt_o = '0;
    // isolate lowest set bit, then remove it before the next port looks
    for (int p = 0; p < RD_PORTS; p++) begin
      gnt_o[p] = rem & ~(rem - NUM_SRC'(1));
      rem      = rem & ~gnt_o[p];
    end
  end
endmodule

// File: rtl/lane_bank_collector.sv
// Banked lane register file with serialised conflict reads, write-back bypass and result hold.
module lane_bank_collector
  import lane_bank_collector_pkg::*;
#(
  parameter int NUM_SRC   = 3,
  parameter int NUM_BANKS = NUM_BANKS_DEF,
  parameter int RD_PORTS  = RD_PORTS_DEF,
  parameter int RF_DEPTH  = 64,
  parameter int IDX_W     = $clog2(RF_DEPTH),
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  lane_bank_collector_if.slave  bus
);
  localparam logic [IDX_W-1:0] BANK_MASK = IDX_W'(NUM_BANKS - 1);

  collector_state_t                      state_q, state_d;
  logic [RF_DEPTH-1:0][DATA_W-1:0]       rf_q, rf_d;
  logic [NUM_SRC-1:0][IDX_W-1:0]         idx_q, idx_d;
  logic [NUM_SRC-1:0]                    pend_q, pend_d;
  logic [NUM_SRC-1:0]                    srcv_q, srcv_d;
  logic [NUM_SRC-1:0][DATA_W-1:0]        data_q, data_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;

  logic [NUM_BANKS-1:0][NUM_SRC-1:0]                 match;
  logic [NUM_BANKS-1:0][RD_PORTS-1:0][NUM_SRC-1:0]   port_gnt;
  logic [NUM_SRC-1:0]                                granted;
  logic                                              ready, valid, accept;

  // bank is the low index bits, so the mask form also covers NUM_BANKS=1
  always_comb begin
    match = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int k = 0; k < NUM_SRC; k++)
        match[b][k] = ((idx_q[k] & BANK_MASK) == IDX_W'(b));
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    lane_bank_collector_bank_grant #(
      .NUM_SRC  (NUM_SRC),
      .RD_PORTS (RD_PORTS)
    ) u_grant (
      .pend_i  (pend_q),
      .match_i (match[b]),
      .gnt_o   (port_gnt[b])
    );
  end

  always_comb begin
    granted = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int p = 0; p < RD_PORTS; p++)
        granted = granted | port_gnt[b][p];
  end

  // write-back is independent of the FSM and never blocks a read
  always_comb begin
    rf_d = rf_q;
    if (bus.I_WB_We) rf_d[bus.I_WB_Idx] = bus.I_WB_Data;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    srcv_d  = srcv_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    valid   = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready  = 1'b1;
        accept = bus.I_Req;
      end
      READ: begin
        for (int k = 0; k < NUM_SRC; k++) begin
          if (granted[k]) begin
            data_d[k] = (bus.I_WB_We && (bus.I_WB_Idx == idx_q[k])) ? bus.I_WB_Data
                                                                    : rf_q[idx_q[k]];
          end
        end
        pend_d = pend_q & ~granted;
        if (pend_d == '0) begin
          state_d = DONE;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        valid = 1'b1;
        ready = ~bus.I_Stall;
        if (!bus.I_Stall) begin
          state_d = IDLE;
          accept  = bus.I_Req;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      idx_d   = bus.I_Src_Idx;
      pend_d  = bus.I_Src_V;
      srcv_d  = bus.I_Src_V;
      data_d  = '0;
      state_d = READ;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rf_q    <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      srcv_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rf_q    <= rf_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      srcv_q  <= srcv_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.O_Ready        = ready;
  assign bus.O_Valid        = valid;
  assign bus.O_Src_V        = srcv_q;
  assign bus.O_Src_Data     = data_q;
  assign bus.O_Conflict_Cnt = cnt_q;
endmodule

// File: tb/tb_lane_bank_collector.sv
// Directed scoreboard bench: dut_a has 2 ports/bank, dut_b has 1 port/bank with a 2-bit counter.
module tb_lane_bank_collector;
  localparam int NS = 3;
  localparam int IW = 6;
  localparam int DW = 32;

  typedef struct {
    logic [NS-1:0]    v;
    logic [NS*DW-1:0] d;
    int               lat;
    int               conf;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int                 sel = 0;
  logic               req = 1'b0;
  logic [NS-1:0]      src_v = '0;
  logic [NS*IW-1:0]   src_idx = '0;
  logic               wb_we = 1'b0;
  logic [IW-1:0]      wb_idx = '0;
  logic [DW-1:0]      wb_data = '0;
  logic               stall = 1'b0;

  lane_bank_collector_if #(.NUM_SRC(NS), .IDX_W(IW), .DATA_W(DW), .CNT_W(16)) if_a ();
  lane_bank_collector_if #(.NUM_SRC(NS), .IDX_W(IW), .DATA_W(DW), .CNT_W(2))  if_b ();

  lane_bank_collector #(.NUM_SRC(NS), .NUM_BANKS(2), .RD_PORTS(2), .RF_DEPTH(64),
                        .IDX_W(IW), .DATA_W(DW), .CNT_W(16))
    dut_a (.clock(clock), .reset(reset), .bus(if_a.slave));
  lane_bank_collector #(.NUM_SRC(NS), .NUM_BANKS(2), .RD_PORTS(1), .RF_DEPTH(64),
                        .IDX_W(IW), .DATA_W(DW), .CNT_W(2))
    dut_b (.clock(clock), .reset(reset), .bus(if_b.slave));

  assign if_a.I_Req = req && (sel == 0);
  assign if_b.I_Req = req && (sel == 1);
  assign if_a.I_Src_V = src_v;    assign if_b.I_Src_V = src_v;
  assign if_a.I_Src_Idx = src_idx; assign if_b.I_Src_Idx = src_idx;
  assign if_a.I_WB_We = wb_we;    assign if_b.I_WB_We = wb_we;
  assign if_a.I_WB_Idx = wb_idx;  assign if_b.I_WB_Idx = wb_idx;
  assign if_a.I_WB_Data = wb_data; assign if_b.I_WB_Data = wb_data;
  assign if_a.I_Stall = stall;    assign if_b.I_Stall = stall;

  logic             o_ready, o_valid;
  logic [NS-1:0]    o_srcv;
  logic [NS*DW-1:0] o_data;
  logic [15:0]      o_cnt;
  assign o_ready = (sel == 1) ? if_b.O_Ready    : if_a.O_Ready;
  assign o_valid = (sel == 1) ? if_b.O_Valid    : if_a.O_Valid;
  assign o_srcv  = (sel == 1) ? if_b.O_Src_V    : if_a.O_Src_V;
  assign o_data  = (sel == 1) ? if_b.O_Src_Data : if_a.O_Src_Data;
  assign o_cnt   = (sel == 1) ? 16'(if_b.O_Conflict_Cnt) : if_a.O_Conflict_Cnt;

  logic [DW-1:0] shadow [64];
  int cnt_exp [2] = '{0, 0};
  int cnt_max [2] = '{65535, 3};
  int rd      [2] = '{2, 1};
  exp_t sb [$];
  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [NS*DW-1:0] got, input logic [NS*DW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NS*IW-1:0] pk(input int a, input int b, input int c);
    return {6'(c), 6'(b), 6'(a)};
  endfunction

  task automatic wb_write(input int i, input logic [DW-1:0] d);
    wb_we = 1'b1; wb_idx = 6'(i); wb_data = d;
    tick();
    wb_we = 1'b0;
    shadow[i] = d;
  endtask

  task automatic drive_cmd(input int s, input logic [NS-1:0] v, input logic [NS*IW-1:0] idx,
                           input bit bp, input logic [IW-1:0] bpi, input logic [DW-1:0] bpd);
    exp_t e;
    int n [2];
    int c;
    logic [IW-1:0] ik;
    sel = s; src_v = v; src_idx = idx;
    #1;
    e.v = v; e.d = '0; n = '{0, 0};
    for (int k = 0; k < NS; k++) begin
      ik = idx[k*IW +: IW];
      if (v[k]) begin
        e.d[k*DW +: DW] = (bp && ik == bpi) ? bpd : shadow[ik];
        n[ik[0]]++;
      end
    end
    e.conf = 0;
    for (int b = 0; b < 2; b++) begin
      c = (n[b] + rd[s] - 1) / rd[s] - 1;
      if (c > e.conf) e.conf = c;
    end
    e.lat = 2 + e.conf;
    sb.push_back(e);
  endtask

  task automatic check_out(input int cyc, input string tag);
    exp_t e;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL %s.sb got=empty exp=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cnt_exp[sel] = (cnt_exp[sel] + e.conf > cnt_max[sel]) ? cnt_max[sel] : cnt_exp[sel] + e.conf;
      chk({tag, ".lat"},  96'(cyc),    96'(e.lat));
      chk({tag, ".srcv"}, 96'(o_srcv), 96'(e.v));
      chk({tag, ".data"}, o_data,      e.d);
      chk({tag, ".cnt"},  96'(o_cnt),  96'(cnt_exp[sel]));
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 2;
    while (!o_valid && cyc < 64) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_cmd(input int s, input logic [NS-1:0] v, input logic [NS*IW-1:0] idx,
                         input bit bp, input logic [IW-1:0] bpi, input logic [DW-1:0] bpd,
                         input string tag);
    int n;
    int cyc;
    drive_cmd(s, v, idx, bp, bpi, bpd);
    req = 1'b1;
    n = 0;
    while (!o_ready && n < 32) begin
      tick();
      n++;
    end
    tick();
    req = 1'b0;
    if (bp) begin
      wb_we = 1'b1; wb_idx = bpi; wb_data = bpd;
      shadow[bpi] = bpd;
    end
    tick();
    wb_we = 1'b0;
    wait_valid(cyc);
    check_out(cyc, tag);
    tick();
  endtask

  initial begin
    logic [NS*DW-1:0] snap;
    int cyc;
    for (int i = 0; i < 64; i++) shadow[i] = '0;
    tick(); tick();
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      chk("rst.ready", 96'(o_ready), 96'(1));
      chk("rst.valid", 96'(o_valid), 96'(0));
      chk("rst.srcv",  96'(o_srcv),  96'(0));
      chk("rst.data",  o_data,       '0);
      chk("rst.cnt",   96'(o_cnt),   96'(0));
    end

    wb_write(4, 32'h11);
    wb_write(5, 32'h22);
    wb_write(7, 32'h33);
    run_cmd(0, 3'b111, pk(4, 5, 7), 1'b0, '0, '0, "noconf");
    run_cmd(1, 3'b111, pk(2, 4, 6), 1'b0, '0, '0, "fullconf");
    run_cmd(0, 3'b111, pk(2, 4, 6), 1'b0, '0, '0, "conf_rd2");

    wb_write(5, 32'h1);
    run_cmd(0, 3'b001, pk(5, 0, 0), 1'b1, 6'd5, 32'hDEAD, "bypass");
    run_cmd(0, 3'b001, pk(5, 0, 0), 1'b0, '0, '0, "rf_after_bp");
    run_cmd(1, 3'b000, pk(4, 5, 7), 1'b0, '0, '0, "nosrc");

    // stall: hold the result, refuse a new command, then accept it on release
    drive_cmd(0, 3'b111, pk(4, 5, 7), 1'b0, '0, '0);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    wait_valid(cyc);
    check_out(cyc, "stall1");
    stall = 1'b1;
    snap = o_data;
    drive_cmd(0, 3'b110, pk(2, 7, 4), 1'b0, '0, '0);
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall.ready", 96'(o_ready), 96'(0));
      tick();
      chk("stall.valid", 96'(o_valid), 96'(1));
      chk("stall.data",  o_data,       snap);
    end
    stall = 1'b0;
    #1;
    chk("release.ready", 96'(o_ready), 96'(1));
    tick();
    req = 1'b0;
    chk("release.read", 96'(o_valid), 96'(0));
    tick();
    wait_valid(cyc);
    check_out(cyc, "stall2");
    tick();

    run_cmd(1, 3'b111, pk(2, 4, 6), 1'b0, '0, '0, "sat1");
    run_cmd(1, 3'b111, pk(2, 4, 6), 1'b0, '0, '0, "sat2");

    // reset while a conflicting command is in READ
    drive_cmd(1, 3'b111, pk(2, 4, 6), 1'b0, '0, '0);
    req = 1'b1;
    tick();
    req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 64; i++) shadow[i] = '0;
    cnt_exp = '{0, 0};
    chk("mid_rst.ready", 96'(o_ready), 96'(1));
    chk("mid_rst.valid", 96'(o_valid), 96'(0));
    chk("mid_rst.cnt",   96'(o_cnt),   96'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst.novalid", 96'(o_valid), 96'(0));
    end
    run_cmd(0, 3'b111, pk(4, 5, 7), 1'b0, '0, '0, "rf_clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lane_bank_collector.md
# lane_bank_collector

Parametrised operand collector for a vector lane: it replaces the fixed odd/even two-bank register file and read stage with NUM_BANKS banks, each with RD_PORTS read ports, serving NUM_SRC source operands. Bank conflicts are resolved by multi-cycle serialised reads instead of a fixed source-to-bank mapping. The block sits between the index-update stage and the network stage of the lane pipeline and owns the lane register file, including its write-back port.

## Interface
Parameters:
- NUM_SRC, 3, number of source operands per command
- NUM_BANKS, 2, register-file banks; power of two, ≥1
- RD_PORTS, 1, read ports per bank; ≥1
- RF_DEPTH, 64, total registers; multiple of NUM_BANKS
- IDX_W, $clog2(RF_DEPTH), register index width
- DATA_W, 32, data width (= width of data_t)
- CNT_W, 16, conflict counter width

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- I_Req  in  1  command valid
- O_Ready  out  1  collector can accept a command this cycle
- I_Src_V  in  NUM_SRC  per-source valid
- I_Src_Idx  in  NUM_SRC*IDX_W  per-source register index (src k at [k*IDX_W +: IDX_W])
- I_WB_We  in  1  write-back enable
- I_WB_Idx  in  IDX_W  write-back index
- I_WB_Data  in  DATA_W  write-back data
- I_Stall  in  1  downstream cannot consume
- O_Valid  out  1  collected operands valid
- O_Src_V  out  NUM_SRC  valid mask of the collected command
- O_Src_Data  out  NUM_SRC*DATA_W  collected data; invalid sources read 0
- O_Conflict_Cnt  out  CNT_W  saturating count of extra conflict cycles

## Operation
- Bank = idx[log2(NUM_BANKS)-1:0]; row = idx >> log2(NUM_BANKS).
- Register-file contents are cleared on reset. Reads are asynchronous from the array. The write port is independent of the read ports, so a write never conflicts with a read.
- FSM states and transitions:
  - IDLE: O_Ready=1. On I_Req, latch I_Src_Idx, set Pending=I_Src_V and O_Src_V=I_Src_V, clear the data collector, then go to READ.
  - READ: for each bank, grant the lowest-numbered RD_PORTS pending sources that map to that bank. Granted data is written into the collector at the clock edge and its pending bits are cleared. When Pending becomes 0 after the edge, go to DONE. Otherwise stay in READ and increment O_Conflict_Cnt by 1, saturating at all-ones. Pending=0 on entry still takes exactly one READ cycle.
  - DONE: O_Valid=1. Outputs are held stable while I_Stall=1. When I_Stall=0 the command is consumed. O_Ready = ~I_Stall, and if I_Req is present the next command is latched and the FSM goes to READ; otherwise it goes to IDLE.
- Write-back bypass: in a READ cycle, if I_WB_We=1 and I_WB_Idx equals a granted source index, that source captures I_WB_Data. The array is written at the same edge.
- Once captured, collector data is not updated by later writes. RAW ordering across commands is the issuer's responsibility.
- I_Req is ignored while O_Ready=0. The upstream stage must hold the command until it is accepted.
- Write-back proceeds in every state, including IDLE and DONE.

## Timing
- Reset values: O_Ready=1, O_Valid=0, O_Src_V=0, O_Src_Data=0, O_Conflict_Cnt=0. FSM is in IDLE.
- Reset asserted mid-operation: the next cycle is IDLE and the in-flight command is discarded with no O_Valid. Register-file contents are cleared.
- Latency: request accepted at cycle 0 gives READ in cycle 1 and O_Valid in cycle 2 when there is no conflict. Each conflict cycle adds one cycle.
- Conflict cycles per command = max over banks of ceil(n_b / RD_PORTS) - 1, where n_b is the number of valid sources mapping to bank b.
- Throughput: one command per 2 cycles with no conflicts and no stall.
- A write at cycle t is visible to an array read at cycle t+1; within cycle t it is visible only through the bypass.

## Structure
- pkg_tpu gains collector_state_t (IDLE, READ, DONE) and default constants for NUM_BANKS and RD_PORTS. data_t is reused from pkg_tpu.
- Sub-module bank_grant: one instance per bank. Inputs are the pending mask and the bank-match mask; output is a one-hot-per-port grant vector (first RD_PORTS set bits, lowest index first).
- The top level holds the array, FSM, collector, bypass and counter.

## Test plan
- No conflict (NUM_BANKS=2, RD_PORTS=2, RF[4]=0x11, RF[5]=0x22, RF[7]=0x33), sources 4,5,7 -> O_Valid in cycle 2, data {0x33,0x22,0x11}, counter stays 0.
- Full conflict (NUM_BANKS=2, RD_PORTS=1), sources 2,4,6 -> three READ cycles, O_Valid in cycle 4, O_Conflict_Cnt=2.
- Bypass: RF[5]=0x1, I_WB_We with idx 5 and data 0xDEAD during READ, source 0 = idx 5 -> O_Src_Data source 0 = 0xDEAD, and RF[5] reads 0xDEAD afterwards.
- Stall: O_Valid with I_Stall=1 for 3 cycles -> outputs stable, O_Ready=0, a concurrent I_Req is not accepted. On release, the back-to-back I_Req is accepted and READ follows next cycle.
- I_Src_V=0 -> one READ cycle, O_Valid in cycle 2, O_Src_Data=0.
- Reset in READ of a conflicting command -> next cycle O_Ready=1, O_Valid=0, O_Conflict_Cnt=0, RF cleared. Counter saturation is checked with CNT_W=2: it holds at 3.
